layer_colorizer: RTL and testbench
==================================

# layer_colorizer

Pipelined, parametrised pixel colorizer. It sits between the world-map/icon pixel sources and the VGA DAC pins. It resolves NUM_ICONS prioritised icon layers over a world-map index and looks the result up in run-time-writable world and icon palettes. Optional per-layer blinking is paced by a frame tick. RGB is registered with a fixed 2-cycle latency, and a delayed video_on is provided for sync alignment.

## Interface
Parameters:
- COLOR_W, 4, bits per colour channel
- WORLD_W, 2, world pixel index width; world palette has 2^WORLD_W entries
- ICON_W, 2, icon index width per layer; icon palette has 2^ICON_W entries, index 0 = transparent
- NUM_ICONS, 2, number of icon layers; layer 0 has highest priority
- ADDR_W, 2, palette write address width; must be ≥ max(WORLD_W, ICON_W)
- BLINK_FRAMES, 30, frame ticks per blink half-period (≥1)

Ports:
- clk  in  1  pixel clock; all state on rising edge
- rst_n  in  1  asynchronous, active-low reset
- video_on  in  1  active display region
- world_pixel  in  WORLD_W  world-map colour index
- icon  in  NUM_ICONS*ICON_W  layer i at bits [i*ICON_W +: ICON_W]
- blink_en  in  NUM_ICONS  per-layer blink enable
- frame_tick  in  1  one-cycle pulse per frame
- pal_we  in  1  palette write strobe
- pal_sel  in  1  0 = world palette, 1 = icon palette
- pal_addr  in  ADDR_W  palette entry
- pal_wdata  in  3*COLOR_W  {R,G,B}
- red, green, blue  out  COLOR_W each  registered colour
- video_on_q  out  1  video_on delayed 2 cycles

## Operation
- Reset values:
  - red/green/blue = 0 and video_on_q = 0.
  - Pipeline registers are 0 and blink phase is 0.
  - Blink counter is 0.
  - The palettes are loaded with their defaults (F = all ones, 8 = MSB only).
- Default world palette:
  - 0 = FFF (white).
  - 1 = 000 (black).
  - 2 = F00 (red).
  - All other entries = 000.
- Default icon palette:
  - 1 = 0F0.
  - 2 = 00F.
  - 3 = FF8.
  - Other non-zero entries = 000.
- Stage 1 registers video_on, world_pixel and the resolved icon index.
  - A layer is visible when its index ≠ 0 and not (blink_en[i] && blink phase = 1).
  - The resolved index is taken from the lowest-numbered visible layer.
  - If no layer is visible, the resolved index is 0.
- Stage 2 produces the output:
  - If the stage-1 video_on is 0, RGB = 0.
  - Otherwise, if the resolved index ≠ 0, RGB = icon palette[index].
  - Otherwise RGB = world palette[world index].
  - The result is registered to the outputs.
  - video_on_q is the stage-1 video_on registered alongside.
- Palette writes are single-cycle with no handshake. When pal_we = 1 at an edge, the selected entry takes pal_wdata.
  - Writes are ignored when pal_addr ≥ table size.
  - Writes to icon palette entry 0 are ignored (transparent is not storable).
- Blink counter:
  - On each frame_tick the counter increments.
  - When it reaches BLINK_FRAMES−1 it wraps to 0 and the phase toggles.
  - frame_tick is ignored between ticks, i.e. the counter advances only on the tick.

## Timing
- Latency is 2 cycles from inputs to RGB and video_on_q. Throughput is 1 pixel per clock with no stalls.
- A write at edge k is visible to lookups from edge k+1 onward. The stage-2 lookup performed at edge k uses the pre-write value.
- A blink phase toggle at edge k affects icon resolution from edge k+1; pixels already in stage 1 are unaffected.
- An rst_n assertion mid-frame immediately forces outputs and pipeline to 0 and restores the default palettes.
  - The first valid output appears 2 edges after rst_n deasserts with video_on high.
- Simultaneous pal_we and pixel traffic to the same entry: the rule above applies, and there is no bypass.

## Test plan
- Reset, then drive video_on=1, world=0, icons=0 → RGB = F,F,F at the second edge; a cycle earlier RGB = 0.
- Drive layer1=2 and layer0=1 → 0,F,0. Then drive layer0=0 and layer1=2 → 0,0,F. Then drive layer0=3 → F,F,8.
- Write world entry 2 = 0x5A3 at edge k while streaming world=2 → output at edge k is F,0,0 and at edge k+1 is 5,A,3. A write to icon entry 0 is ignored, so world colour still shows.
- Set BLINK_FRAMES=2, blink_en=01 and layer0=1 over world=0, then pulse frame_tick 2 times → output toggles between 0,F,0 and F,F,F every 2 ticks. Layer 1 is unaffected.
- Toggle video_on low mid-stream → RGB = 0 and video_on_q = 0 exactly 2 cycles later.
- Assert rst_n low mid-line after palette writes → outputs are 0 immediately and default colours return after release.

Source files
------------

// File: rtl/layer_colorizer.sv
// Two-stage pixel colorizer: resolves prioritised, optionally blinking icon layers over a
// world-map index and maps the winner through run-time writable world/icon palettes.
`timescale 1ns/1ps
module layer_colorizer #(
    parameter int unsigned COLOR_W      = 4,
    parameter int unsigned WORLD_W      = 2,
    parameter int unsigned ICON_W       = 2,
    parameter int unsigned NUM_ICONS    = 2,
    parameter int unsigned ADDR_W       = 2,
    parameter int unsigned BLINK_FRAMES = 30
) (
    input  logic                          clk,
    input  logic                          rst_n,
    input  logic                          video_on,
    input  logic [WORLD_W-1:0]            world_pixel,
    input  logic [NUM_ICONS*ICON_W-1:0]   icon,
    input  logic [NUM_ICONS-1:0]          blink_en,
    input  logic                          frame_tick,
    input  logic                          pal_we,
    input  logic                          pal_sel,
    input  logic [ADDR_W-1:0]             pal_addr,
    input  logic [3*COLOR_W-1:0]          pal_wdata,
    output logic [COLOR_W-1:0]            red,
    output logic [COLOR_W-1:0]            green,
    output logic [COLOR_W-1:0]            blue,
    output logic                          video_on_q
);
    localparam int unsigned RGB_W   = 3 * COLOR_W;
    localparam int unsigned WORLD_N = 1 << WORLD_W;
    localparam int unsigned ICON_N  = 1 << ICON_W;
    localparam int unsigned CNT_W   = (BLINK_FRAMES > 1) ? $clog2(BLINK_FRAMES) : 1;

    localparam logic [COLOR_W-1:0] C_F      = '1;
    localparam logic [COLOR_W-1:0] C_0      = '0;
    localparam logic [COLOR_W-1:0] C_8      = COLOR_W'(1 << (COLOR_W - 1));
    localparam logic [CNT_W-1:0]   CNT_LAST = CNT_W'(BLINK_FRAMES - 1);

    function automatic logic [RGB_W-1:0] world_default(input int unsigned idx);
        case (idx)
            0:       world_default = {C_F, C_F, C_F};
            2:       world_default = {C_F, C_0, C_0};
            default: world_default = '0;
        endcase
    endfunction

    function automatic logic [RGB_W-1:0] icon_default(input int unsigned idx);
        case (idx)
            1:       icon_default = {C_0, C_F, C_0};
            2:       icon_default = {C_0, C_0, C_F};
            3:       icon_default = {C_F, C_F, C_8};
            default: icon_default = '0;
        endcase
    endfunction

    logic [RGB_W-1:0]   world_pal_q [WORLD_N];
    logic [RGB_W-1:0]   world_pal_d [WORLD_N];
    logic [RGB_W-1:0]   icon_pal_q  [ICON_N];
    logic [RGB_W-1:0]   icon_pal_d  [ICON_N];
    logic               s1_video_on_q, s1_video_on_d;
    logic [WORLD_W-1:0] s1_world_q, s1_world_d;
    logic [ICON_W-1:0]  s1_icon_q, s1_icon_d;
    logic [RGB_W-1:0]   rgb_q, rgb_d;
    logic               video_on_d;
    logic [CNT_W-1:0]   blink_cnt_q, blink_cnt_d;
    logic               blink_phase_q, blink_phase_d;

    // Palette writes; out-of-range addresses and the transparent icon slot are dropped.
    always_comb begin
        world_pal_d = world_pal_q;
        icon_pal_d  = icon_pal_q;
        if (pal_we) begin
            if (!pal_sel) begin
                if ((pal_addr >> WORLD_W) == '0)
                    world_pal_d[pal_addr[WORLD_W-1:0]] = pal_wdata;
            end else if (((pal_addr >> ICON_W) == '0) && (pal_addr != '0)) begin
                icon_pal_d[pal_addr[ICON_W-1:0]] = pal_wdata;
            end
        end
    end

    // Blink pacing: advance only on frame ticks, toggle phase on wrap.
    always_comb begin
        blink_cnt_d   = blink_cnt_q;
        blink_phase_d = blink_phase_q;
        if (frame_tick) begin
            if (blink_cnt_q == CNT_LAST) begin
                blink_cnt_d   = '0;
                blink_phase_d = ~blink_phase_q;
            end else begin
                blink_cnt_d = blink_cnt_q + CNT_W'(1);
            end
        end
    end

    // Stage 1: walk from lowest to highest priority so layer 0 wins last.
    always_comb begin
        s1_video_on_d = video_on;
        s1_world_d    = world_pixel;
        s1_icon_d     = '0;
        for (int i = int'(NUM_ICONS) - 1; i >= 0; i--) begin
            if ((icon[i*ICON_W +: ICON_W] != '0) && !(blink_en[i] && blink_phase_q))
                s1_icon_d = icon[i*ICON_W +: ICON_W];
        end
    end

    // Stage 2: palette lookup against the pre-write palette contents.
    always_comb begin
        rgb_d      = '0;
        video_on_d = s1_video_on_q;
        if (s1_video_on_q) begin
            if (s1_icon_q != '0) rgb_d = icon_pal_q[s1_icon_q];
            else                 rgb_d = world_pal_q[s1_world_q];
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int unsigned i = 0; i < WORLD_N; i++) world_pal_q[i] <= world_default(i);
            for (int unsigned i = 0; i < ICON_N; i++)  icon_pal_q[i]  <= icon_default(i);
            s1_video_on_q <= 1'b0;
            s1_world_q    <= '0;
            s1_icon_q     <= '0;
            rgb_q         <= '0;
            video_on_q    <= 1'b0;
            blink_cnt_q   <= '0;
            blink_phase_q <= 1'b0;
        end else begin
            world_pal_q   <= world_pal_d;
            icon_pal_q    <= icon_pal_d;
            s1_video_on_q <= s1_video_on_d;
            s1_world_q    <= s1_world_d;
            s1_icon_q     <= s1_icon_d;
            rgb_q         <= rgb_d;
            video_on_q    <= video_on_d;
            blink_cnt_q   <= blink_cnt_d;
            blink_phase_q <= blink_phase_d;
        end
    end

    assign red   = rgb_q[RGB_W-1 -: COLOR_W];
    assign green = rgb_q[2*COLOR_W-1 -: COLOR_W];
    assign blue  = rgb_q[COLOR_W-1:0];

endmodule

// File: tb/tb_layer_colorizer.sv
// Scoreboard bench for layer_colorizer: driver queues hand-computed colours, monitor checks them.
`timescale 1ns/1ps
module tb_layer_colorizer;
    logic        clk = 1'b0;
    logic        rst_n;
    logic        video_on;
    logic [1:0]  world_pixel;
    logic [3:0]  icon;
    logic [1:0]  blink_en;
    logic        frame_tick;
    logic        pal_we;
    logic        pal_sel;
    logic [1:0]  pal_addr;
    logic [11:0] pal_wdata;
    logic [3:0]  red, green, blue;
    logic        video_on_q;

    layer_colorizer #(
        .COLOR_W(4), .WORLD_W(2), .ICON_W(2), .NUM_ICONS(2), .ADDR_W(2), .BLINK_FRAMES(2)
    ) dut (
        .clk(clk), .rst_n(rst_n), .video_on(video_on), .world_pixel(world_pixel),
        .icon(icon), .blink_en(blink_en), .frame_tick(frame_tick), .pal_we(pal_we),
        .pal_sel(pal_sel), .pal_addr(pal_addr), .pal_wdata(pal_wdata),
        .red(red), .green(green), .blue(blue), .video_on_q(video_on_q)
    );

    always #5 clk = ~clk;

    typedef struct {
        int unsigned due;
        logic        vo;
        logic [11:0] rgb;
        string       name;
    } exp_t;

    exp_t        sb_q[$];
    int unsigned cyc = 0;
    int          n_checks = 0;
    int          n_fail = 0;

    always @(posedge clk) cyc <= cyc + 1;

    function automatic void push(input int unsigned due, input logic vo,
                                 input logic [11:0] rgb, input string name);
        exp_t e;
        e.due = due; e.vo = vo; e.rgb = rgb; e.name = name;
        sb_q.push_back(e);
    endfunction

    // Monitor: compare every entry whose due cycle has arrived, at the falling edge.
    initial begin
        forever begin
            int i;
            @(negedge clk);
            i = 0;
            while (i < sb_q.size()) begin
                if (sb_q[i].due <= cyc) begin
                    n_checks++;
                    if ({red, green, blue} !== sb_q[i].rgb || video_on_q !== sb_q[i].vo) begin
                        n_fail++;
                        $display("FAIL %s: got rgb=%h vo=%b, expected rgb=%h vo=%b (cycle %0d)",
                                 sb_q[i].name, {red, green, blue}, video_on_q,
                                 sb_q[i].rgb, sb_q[i].vo, cyc);
                    end
                    sb_q.delete(i);
                end else begin
                    i++;
                end
            end
        end
    end

    task automatic step(input logic vo, input logic [1:0] w, input logic [3:0] ic,
                        input logic [1:0] be, input logic tick, input logic we,
                        input logic sel, input logic [1:0] addr, input logic [11:0] wd,
                        input logic [11:0] exp_rgb, input string name);
        @(negedge clk);
        video_on = vo; world_pixel = w; icon = ic; blink_en = be; frame_tick = tick;
        pal_we = we; pal_sel = sel; pal_addr = addr; pal_wdata = wd;
        push(cyc + 2, vo, vo ? exp_rgb : 12'h000, name);
    endtask

    task automatic pix(input logic vo, input logic [1:0] w, input logic [3:0] ic,
                       input logic [1:0] be, input logic tick, input logic [11:0] exp_rgb,
                       input string name);
        step(vo, w, ic, be, tick, 1'b0, 1'b0, 2'd0, 12'h000, exp_rgb, name);
    endtask

    task automatic drain();
        for (int k = 0; k < 20 && sb_q.size() != 0; k++) @(negedge clk);
    endtask

    initial begin
        rst_n = 1'b0; video_on = 1'b0; world_pixel = '0; icon = '0; blink_en = '0;
        frame_tick = 1'b0; pal_we = 1'b0; pal_sel = 1'b0; pal_addr = '0; pal_wdata = '0;

        repeat (2) begin
            @(negedge clk);
            push(cyc + 1, 1'b0, 12'h000, "reset_out");
        end
        n_checks++;
        if ({red, green, blue} !== 12'h000) begin
            n_fail++;
            $display("FAIL reset_rgb_held: got rgb=%h", {red, green, blue});
        end
        n_checks++;
        if (video_on_q !== 1'b0) begin
            n_fail++;
            $display("FAIL reset_vo_held: got vo=%b", video_on_q);
        end
        @(negedge clk);
        rst_n = 1'b1;

        // Basic world colour and two-cycle latency
        pix(1, 2'd0, 4'b0000, 2'b00, 0, 12'hFFF, "world0_white");
        push(cyc + 1, 1'b0, 12'h000, "latency_zero");
        // Layer priority
        pix(1, 2'd0, 4'b1001, 2'b00, 0, 12'h0F0, "l0_over_l1");
        pix(1, 2'd0, 4'b1000, 2'b00, 0, 12'h00F, "l1_only");
        pix(1, 2'd0, 4'b1011, 2'b00, 0, 12'hFF8, "l0_idx3");
        // World palette write with same-entry traffic
        pix(1, 2'd2, 4'b0000, 2'b00, 0, 12'hF00, "world2_default");
        pix(1, 2'd2, 4'b0000, 2'b00, 0, 12'hF00, "world2_pre_write");
        step(1, 2'd2, 4'b0000, 2'b00, 0, 1, 0, 2'd2, 12'h5A3, 12'h5A3, "world2_post_write");
        pix(1, 2'd2, 4'b0000, 2'b00, 0, 12'h5A3, "world2_new");
        step(1, 2'd2, 4'b0000, 2'b00, 0, 1, 1, 2'd0, 12'h123, 12'h5A3, "icon0_write_ignored");
        step(1, 2'd2, 4'b0000, 2'b00, 0, 1, 1, 2'd1, 12'h3C7, 12'h5A3, "icon1_write_bg");
        pix(1, 2'd2, 4'b0001, 2'b00, 0, 12'h3C7, "icon1_written");
        pix(1, 2'd2, 4'b0000, 2'b00, 0, 12'h5A3, "transparent_after_icon0_write");
        // video_on gating
        pix(0, 2'd2, 4'b0001, 2'b00, 0, 12'h000, "video_off");
        pix(1, 2'd2, 4'b0000, 2'b00, 0, 12'h5A3, "video_back_on");
        // Blinking on layer 0 only
        step(1, 2'd0, 4'b0000, 2'b00, 0, 1, 1, 2'd1, 12'h0F0, 12'hFFF, "icon1_restore");
        pix(1, 2'd0, 4'b0001, 2'b01, 1, 12'h0F0, "blink_t1");
        pix(1, 2'd0, 4'b0001, 2'b01, 0, 12'h0F0, "blink_a");
        pix(1, 2'd0, 4'b0001, 2'b01, 1, 12'h0F0, "blink_t2_same_pixel");
        pix(1, 2'd0, 4'b0001, 2'b01, 0, 12'hFFF, "blink_hidden");
        pix(1, 2'd0, 4'b1001, 2'b01, 0, 12'h00F, "blink_l1_unaffected");
        pix(1, 2'd0, 4'b0001, 2'b01, 1, 12'hFFF, "blink_t3");
        pix(1, 2'd0, 4'b0001, 2'b01, 1, 12'hFFF, "blink_t4_same_pixel");
        pix(1, 2'd0, 4'b0001, 2'b01, 0, 12'h0F0, "blink_shown_again");
        pix(1, 2'd0, 4'b0001, 2'b00, 0, 12'h0F0, "blink_disabled");
        // Palette writes then asynchronous reset mid-line
        step(1, 2'd0, 4'b0000, 2'b00, 0, 1, 0, 2'd0, 12'h123, 12'h123, "world0_written");
        step(1, 2'd0, 4'b0000, 2'b00, 0, 1, 1, 2'd2, 12'h777, 12'h123, "icon2_write_bg");
        pix(1, 2'd0, 4'b0010, 2'b00, 0, 12'h777, "icon2_written");
        pix(1, 2'd0, 4'b0000, 2'b00, 0, 12'h123, "world0_stream");
        drain();
        @(negedge clk);
        video_on = 1'b1; world_pixel = 2'd0; icon = 4'b0000; blink_en = 2'b00;
        frame_tick = 1'b0; pal_we = 1'b0;
        #1 rst_n = 1'b0;
        #1;
        n_checks++;
        if ({red, green, blue} !== 12'h000) begin
            n_fail++;
            $display("FAIL midline_reset_rgb: got rgb=%h", {red, green, blue});
        end
        n_checks++;
        if (video_on_q !== 1'b0) begin
            n_fail++;
            $display("FAIL midline_reset_vo: got vo=%b", video_on_q);
        end
        #1 rst_n = 1'b1;
        push(cyc + 1, 1'b0, 12'h000, "reset_flush");
        push(cyc + 2, 1'b1, 12'hFFF, "reset_world_default");
        pix(1, 2'd0, 4'b0010, 2'b00, 0, 12'h00F, "reset_icon_default");
        pix(1, 2'd2, 4'b0000, 2'b00, 0, 12'hF00, "reset_world2_default");
        pix(0, 2'd0, 4'b0000, 2'b00, 0, 12'h000, "tail_off");

        drain();
        @(negedge clk);
        #1;
        while (sb_q.size() != 0) begin
            n_checks++;
            n_fail++;
            $display("FAIL %s: never compared, expected rgb=%h vo=%b", sb_q[0].name,
                     sb_q[0].rgb, sb_q[0].vo);
            sb_q.delete(0);
        end
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
